// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard unit - load-use / RAW stall, branch flush, operand forward select.
// Latency : zero-cycle (combinational) control outputs; stall_cycles updates on the clock edge.
// Backpr. : stall_fetch holds PC and IF/ID while bubble_id_ex inserts a nop; branch flush overrides stall.
//
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding
//   (EX > MEM > WB priority, only load-use stalls). Undefined: no forwarding,
//   any RAW match in EX/MEM/WB stalls and bubbles.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_rs_id, id_rt_id             decode source register ids
//   id_uses_rs, id_uses_rt         decode instruction reads rs / rt
//   ex_writeback_reg_id            EX destination register id (ID/EX output)
//   ex_write_to_regfile            EX instruction writes the regfile
//   ex_mem_read                    EX instruction is a load
//   ex_branch_taken                branch resolved taken in EX
//   stall_fetch                    hold PC and IF/ID
//   bubble_id_ex                   ID/EX captures zero control
//   flush_if_id                    IF/ID captures a nop
//   fwd_a_sel, fwd_b_sel           00 regfile, 01 EX, 10 MEM, 11 WB
//   stall_cycles                   saturating count of stalled cycles
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_id,
    input  logic [4:0]  id_rt_id,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_writeback_reg_id,
    input  logic        ex_write_to_regfile,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    output logic        stall_fetch,
    output logic        bubble_id_ex,
    output logic        flush_if_id,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [15:0] stall_cycles
);

    // In-flight tracker: what was in EX last cycle (MEM) and two cycles ago (WB).
    logic [4:0] mem_reg;
    logic       mem_we;
    logic       mem_load;
    logic [4:0] wb_reg;
    logic       wb_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_reg  <= 5'd0;
            mem_we   <= 1'b0;
            mem_load <= 1'b0;
            wb_reg   <= 5'd0;
            wb_we    <= 1'b0;
        end else begin
            mem_reg  <= ex_writeback_reg_id;
            mem_we   <= ex_write_to_regfile;
            mem_load <= ex_mem_read;
            wb_reg   <= mem_reg;
            wb_we    <= mem_we;
        end
    end

    // The MEM load flag is kept with the entry for observability; a load that has
    // reached MEM has its data available, so no decision depends on it here.
    logic unused_mem_load;
    assign unused_mem_load = mem_load;

    // r0 is hard-wired zero, so it never creates a dependency.
    function automatic logic src_match(input logic uses, input logic [4:0] src,
                                       input logic we, input logic [4:0] dst);
        return uses && we && (src == dst) && (src != 5'd0);
    endfunction

    logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
    always_comb begin
        ex_a  = src_match(id_uses_rs, id_rs_id, ex_write_to_regfile, ex_writeback_reg_id);
        ex_b  = src_match(id_uses_rt, id_rt_id, ex_write_to_regfile, ex_writeback_reg_id);
        mem_a = src_match(id_uses_rs, id_rs_id, mem_we, mem_reg);
        mem_b = src_match(id_uses_rt, id_rt_id, mem_we, mem_reg);
        wb_a  = src_match(id_uses_rs, id_rs_id, wb_we, wb_reg);
        wb_b  = src_match(id_uses_rt, id_rt_id, wb_we, wb_reg);
    end

    logic       hazard;
    logic [1:0] sel_a, sel_b;

`ifdef HAZARD_FORWARDING_EN
    // Youngest producer wins: EX result is newer than MEM, MEM newer than WB.
    function automatic logic [1:0] pick(input logic ex_m, input logic mem_m, input logic wb_m);
        if (ex_m)       return 2'b01;
        else if (mem_m) return 2'b10;
        else if (wb_m)  return 2'b11;
        else            return 2'b00;
    endfunction

    always_comb begin
        hazard = (ex_a || ex_b) && ex_mem_read;
        sel_a  = pick(ex_a, mem_a, wb_a);
        sel_b  = pick(ex_b, mem_b, wb_b);
    end
`else
    always_comb begin
        hazard = ex_a || ex_b || mem_a || mem_b || wb_a || wb_b;
        sel_a  = 2'b00;
        sel_b  = 2'b00;
    end
`endif

    // Outputs are masked during reset so a stall driven by live EX inputs also
    // drops the moment rst rises.
    always_comb begin
        stall_fetch  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        fwd_a_sel    = 2'b00;
        fwd_b_sel    = 2'b00;
        if (!rst) begin
            // A taken branch kills the decode instruction, so its hazard is moot.
            stall_fetch  = hazard && !ex_branch_taken;
            bubble_id_ex = hazard || ex_branch_taken;
            flush_if_id  = ex_branch_taken;
            fwd_a_sel    = sel_a;
            fwd_b_sel    = sel_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (stall_fetch && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs_id, id_rt_id;
    logic        id_uses_rs, id_uses_rt;
    logic [4:0]  ex_writeback_reg_id;
    logic        ex_write_to_regfile, ex_mem_read, ex_branch_taken;
    logic        stall_fetch, bubble_id_ex, flush_if_id;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cycles;

    int compared   = 0;
    int mismatched = 0;

    hazard_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_rs_id            (id_rs_id),
        .id_rt_id            (id_rt_id),
        .id_uses_rs          (id_uses_rs),
        .id_uses_rt          (id_uses_rt),
        .ex_writeback_reg_id (ex_writeback_reg_id),
        .ex_write_to_regfile (ex_write_to_regfile),
        .ex_mem_read         (ex_mem_read),
        .ex_branch_taken     (ex_branch_taken),
        .stall_fetch         (stall_fetch),
        .bubble_id_ex        (bubble_id_ex),
        .flush_if_id         (flush_if_id),
        .fwd_a_sel           (fwd_a_sel),
        .fwd_b_sel           (fwd_b_sel),
        .stall_cycles        (stall_cycles)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [4:0] r, input logic we, input logic ld, input logic br);
        ex_writeback_reg_id = r;
        ex_write_to_regfile = we;
        ex_mem_read         = ld;
        ex_branch_taken     = br;
    endtask

    task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt);
        id_rs_id   = rs;
        id_rt_id   = rt;
        id_uses_rs = urs;
        id_uses_rt = urt;
    endtask

    // Idle inputs and let the tracker drain.
    task automatic drain();
        drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
        drive_id(5'd0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
        drive_id(5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL rst_stall: got %b want 0", stall_fetch); end
        compared++; if (bubble_id_ex !== 1'b0) begin mismatched++; $display("FAIL rst_bubble: got %b want 0", bubble_id_ex); end
        compared++; if (flush_if_id !== 1'b0) begin mismatched++; $display("FAIL rst_flush: got %b want 0", flush_if_id); end
        compared++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin mismatched++; $display("FAIL rst_fwd: got %b%b want 0000", fwd_a_sel, fwd_b_sel); end
        compared++; if (stall_cycles !== 16'd0) begin mismatched++; $display("FAIL rst_count: got %0h want 0", stall_cycles); end
        tick();
        rst = 1'b0;
        tick();
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL post_rst_stall: got %b want 0", stall_fetch); end
    endtask

    task automatic test_r0();
        drive_ex(5'd0, 1'b1, 1'b0, 1'b0);
        drive_id(5'd0, 5'd0, 1'b1, 1'b1);
        #1;
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL r0_stall: got %b want 0", stall_fetch); end
        compared++; if (fwd_a_sel !== 2'b00) begin mismatched++; $display("FAIL r0_fwd_a: got %b want 00", fwd_a_sel); end
        tick();
        compared++; if (bubble_id_ex !== 1'b0) begin mismatched++; $display("FAIL r0_mem_bubble: got %b want 0", bubble_id_ex); end
        drain();
    endtask

    task automatic test_uses_bits();
        // Register ids match but decode does not read them.
        drive_ex(5'd4, 1'b1, 1'b1, 1'b0);
        drive_id(5'd4, 5'd4, 1'b0, 1'b0);
        #1;
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL nouse_stall: got %b want 0", stall_fetch); end
        compared++; if (bubble_id_ex !== 1'b0) begin mismatched++; $display("FAIL nouse_bubble: got %b want 0", bubble_id_ex); end
        // Different register: no match anywhere.
        drive_ex(5'd9, 1'b1, 1'b0, 1'b0);
        drive_id(5'd1, 5'd2, 1'b1, 1'b1);
        #1;
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL nomatch_stall: got %b want 0", stall_fetch); end
        compared++; if (fwd_b_sel !== 2'b00) begin mismatched++; $display("FAIL nomatch_fwd_b: got %b want 00", fwd_b_sel); end
        drain();
    endtask

    task automatic test_ex_raw();
        pulse_reset();
`ifdef HAZARD_FORWARDING_EN
        drive_ex(5'd5, 1'b1, 1'b0, 1'b0);
        drive_id(5'd5, 5'd0, 1'b1, 1'b0);
        #1;
        compared++; if (fwd_a_sel !== 2'b01) begin mismatched++; $display("FAIL exfwd_a: got %b want 01", fwd_a_sel); end
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL exfwd_stall: got %b want 0", stall_fetch); end
        compared++; if (bubble_id_ex !== 1'b0) begin mismatched++; $display("FAIL exfwd_bubble: got %b want 0", bubble_id_ex); end
        tick();
        compared++; if (stall_cycles !== 16'd0) begin mismatched++; $display("FAIL exfwd_count: got %0d want 0", stall_cycles); end
`else
        drive_ex(5'd3, 1'b1, 1'b0, 1'b0);
        drive_id(5'd3, 5'd0, 1'b1, 1'b0);
        #1;
        compared++; if (stall_fetch !== 1'b1) begin mismatched++; $display("FAIL raw_stall_ex: got %b want 1", stall_fetch); end
        compared++; if (bubble_id_ex !== 1'b1) begin mismatched++; $display("FAIL raw_bubble_ex: got %b want 1", bubble_id_ex); end
        compared++; if (fwd_a_sel !== 2'b00) begin mismatched++; $display("FAIL raw_fwd_a: got %b want 00", fwd_a_sel); end
        tick();
        drive_ex(5'd0, 1'b0, 1'b0, 1'b0);  // bubble now in EX
        #1;
        compared++; if (stall_fetch !== 1'b1) begin mismatched++; $display("FAIL raw_stall_mem: got %b want 1", stall_fetch); end
        tick();
        compared++; if (stall_fetch !== 1'b1) begin mismatched++; $display("FAIL raw_stall_wb: got %b want 1", stall_fetch); end
        tick();
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL raw_release: got %b want 0", stall_fetch); end
        compared++; if (stall_cycles !== 16'd3) begin mismatched++; $display("FAIL raw_count: got %0d want 3", stall_cycles); end
`endif
        drain();
    endtask

    task automatic test_load_use();
        pulse_reset();
        drive_ex(5'd7, 1'b1, 1'b1, 1'b0);
        drive_id(5'd0, 5'd7, 1'b0, 1'b1);
        #1;
        compared++; if (stall_fetch !== 1'b1) begin mismatched++; $display("FAIL lu_stall: got %b want 1", stall_fetch); end
        compared++; if (bubble_id_ex !== 1'b1) begin mismatched++; $display("FAIL lu_bubble: got %b want 1", bubble_id_ex); end
        tick();
        drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
        #1;
`ifdef HAZARD_FORWARDING_EN
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL lu_release: got %b want 0", stall_fetch); end
        compared++; if (fwd_b_sel !== 2'b10) begin mismatched++; $display("FAIL lu_fwd_b_mem: got %b want 10", fwd_b_sel); end
        compared++; if (stall_cycles !== 16'd1) begin mismatched++; $display("FAIL lu_count: got %0d want 1", stall_cycles); end
        tick();
        compared++; if (fwd_b_sel !== 2'b11) begin mismatched++; $display("FAIL lu_fwd_b_wb: got %b want 11", fwd_b_sel); end
`else
        compared++; if (stall_fetch !== 1'b1) begin mismatched++; $display("FAIL lu_stall_mem: got %b want 1", stall_fetch); end
        tick();
        tick();
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL lu_release: got %b want 0", stall_fetch); end
        compared++; if (stall_cycles !== 16'd3) begin mismatched++; $display("FAIL lu_count: got %0d want 3", stall_cycles); end
`endif
        drain();
    endtask

    task automatic test_branch();
        pulse_reset();
        drive_ex(5'd4, 1'b1, 1'b1, 1'b1);
        drive_id(5'd0, 5'd4, 1'b0, 1'b1);
        #1;
        compared++; if (flush_if_id !== 1'b1) begin mismatched++; $display("FAIL br_flush: got %b want 1", flush_if_id); end
        compared++; if (bubble_id_ex !== 1'b1) begin mismatched++; $display("FAIL br_bubble: got %b want 1", bubble_id_ex); end
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL br_stall: got %b want 0", stall_fetch); end
        tick();
        compared++; if (stall_cycles !== 16'd0) begin mismatched++; $display("FAIL br_count: got %0d want 0", stall_cycles); end
        drain();
    endtask

    task automatic test_back_to_back();
        drive_ex(5'd6, 1'b1, 1'b0, 1'b0);
        drive_id(5'd0, 5'd0, 1'b0, 1'b0);
        tick();
`ifdef HAZARD_FORWARDING_EN
        // r6 in both EX and MEM: the EX copy is the newest.
        drive_id(5'd6, 5'd0, 1'b1, 1'b0);
        #1;
        compared++; if (fwd_a_sel !== 2'b01) begin mismatched++; $display("FAIL b2b_fwd_ex: got %b want 01", fwd_a_sel); end
        tick();
        drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        compared++; if (fwd_a_sel !== 2'b10) begin mismatched++; $display("FAIL b2b_fwd_mem: got %b want 10", fwd_a_sel); end
`else
        // Producer already past EX: the MEM and WB matches alone must stall.
        drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
        drive_id(5'd6, 5'd0, 1'b1, 1'b0);
        #1;
        compared++; if (stall_fetch !== 1'b1) begin mismatched++; $display("FAIL b2b_stall_mem: got %b want 1", stall_fetch); end
        tick();
        compared++; if (stall_fetch !== 1'b1) begin mismatched++; $display("FAIL b2b_stall_wb: got %b want 1", stall_fetch); end
        tick();
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL b2b_release: got %b want 0", stall_fetch); end
`endif
        drain();
    endtask

    task automatic test_saturation();
        pulse_reset();
        // Load-use held steady keeps the stall asserted in either build.
        drive_ex(5'd2, 1'b1, 1'b1, 1'b0);
        drive_id(5'd2, 5'd0, 1'b1, 1'b0);
        repeat (70000) tick();
        compared++; if (stall_cycles !== 16'hFFFF) begin mismatched++; $display("FAIL sat_count: got %0h want ffff", stall_cycles); end
        compared++; if (stall_fetch !== 1'b1) begin mismatched++; $display("FAIL sat_stall: got %b want 1", stall_fetch); end
        rst = 1'b1;
        #1;
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL midrst_stall: got %b want 0", stall_fetch); end
        compared++; if (bubble_id_ex !== 1'b0) begin mismatched++; $display("FAIL midrst_bubble: got %b want 0", bubble_id_ex); end
        compared++; if (stall_cycles !== 16'd0) begin mismatched++; $display("FAIL midrst_count: got %0h want 0", stall_cycles); end
        tick();
        drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL postrst_stall: got %b want 0", stall_fetch); end
        tick();
        compared++; if (stall_fetch !== 1'b0) begin mismatched++; $display("FAIL postrst_stall2: got %b want 0", stall_fetch); end
        compared++; if (stall_cycles !== 16'd0) begin mismatched++; $display("FAIL postrst_count: got %0h want 0", stall_cycles); end
        drain();
    endtask

    initial begin
        test_reset();
        test_r0();
        test_uses_bits();
        test_ex_raw();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
